// File: rtl/sqrt_arbiter.sv
// ============================================================================
//  Module      : sqrt_arbiter
//  Description : Round-robin arbiter that shares one iterative square-root
//                core among NREQ requesters. Latches the granted operand,
//                sequences the core (launch / wait / clear) and returns a
//                registered result with requester id and timeout error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sqrt_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                       clk,
  input  logic                       enable,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0]            req_sign,
  input  logic [7*NREQ-1:0]          req_exp,
  input  logic [11*NREQ-1:0]         req_mant,
  input  logic [4*NREQ-1:0]          req_flags,
  output logic                       core_enable,
  output logic                       core_n_valid,
  output logic                       core_sign,
  output logic [6:0]                 core_exp,
  output logic [10:0]                core_mant,
  output logic                       core_is_nan,
  output logic                       core_is_pinf,
  output logic                       core_is_ninf,
  output logic                       core_is_num,
  input  logic                       core_result,
  input  logic                       core_sign_o,
  input  logic [6:0]                 core_exp_o,
  input  logic [10:0]                core_mant_o,
  input  logic                       core_nan_o,
  input  logic                       core_pinf_o,
  input  logic                       core_ninf_o,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic                       rsp_sign,
  output logic [6:0]                 rsp_exp,
  output logic [10:0]                rsp_mant,
  output logic                       rsp_nan,
  output logic                       rsp_pinf,
  output logic                       rsp_ninf,
  output logic                       rsp_err,
  output logic                       busy
);

  localparam int IDW = $clog2(NREQ);
  // Counter must hold TIMEOUT+1 without wrapping
  localparam int CW  = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] c_tmo = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [IDW-1:0]      r_ptr;
  logic [IDW-1:0]      r_grant;
  logic [CW-1:0]       r_cnt;
  logic                r_op_sign;
  logic [6:0]          r_op_exp;
  logic [10:0]         r_op_mant;
  logic [3:0]          r_op_flags;
  logic                r_rsp_sign;
  logic [6:0]          r_rsp_exp;
  logic [10:0]         r_rsp_mant;
  logic                r_rsp_nan;
  logic                r_rsp_pinf;
  logic                r_rsp_ninf;
  logic                r_rsp_err;
  logic                w_found;
  logic [IDW-1:0]      w_gnt;
  logic [NREQ-1:0]     w_ready;
  logic [NREQ-1:0]     w_rsp_v;

  // Round-robin search: first requester above the pointer, wrapping modulo NREQ
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_gnt   = IDW'(idx);
      end
    end
  end

  // Accept pulse only while idle; forced low while reset is held
  always_comb begin
    w_ready = '0;
    if (enable && (r_state == S_IDLE) && w_found) w_ready[w_gnt] = 1'b1;
  end

  // Next-state decode for the job sequencer
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_state_nx = S_LAUNCH;
      S_LAUNCH: w_state_nx = S_WAIT;
      S_WAIT:   if (core_result || (r_cnt == c_tmo)) w_state_nx = S_RESP;
      S_RESP:   w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge enable) begin
    if (!enable) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  // Grant pointer, operand latch and wait counter
  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      r_ptr      <= IDW'(NREQ - 1);
      r_grant    <= '0;
      r_cnt      <= '0;
      r_op_sign  <= 1'b0;
      r_op_exp   <= '0;
      r_op_mant  <= '0;
      r_op_flags <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_ptr      <= w_gnt;
            r_grant    <= w_gnt;
            r_op_sign  <= req_sign[w_gnt];
            r_op_exp   <= req_exp[7*int'(w_gnt) +: 7];
            r_op_mant  <= req_mant[11*int'(w_gnt) +: 11];
            r_op_flags <= req_flags[4*int'(w_gnt) +: 4];
          end
        end
        S_LAUNCH: r_cnt <= '0;
        S_WAIT:   r_cnt <= r_cnt + 1'b1;
        default:  ;
      endcase
    end
  end

  // Response capture: a core result beats a simultaneous timeout
  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      r_rsp_sign <= 1'b0;
      r_rsp_exp  <= '0;
      r_rsp_mant <= '0;
      r_rsp_nan  <= 1'b0;
      r_rsp_pinf <= 1'b0;
      r_rsp_ninf <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else if (r_state == S_WAIT) begin
      if (core_result) begin
        r_rsp_sign <= core_sign_o;
        r_rsp_exp  <= core_exp_o;
        r_rsp_mant <= core_mant_o;
        r_rsp_nan  <= core_nan_o;
        r_rsp_pinf <= core_pinf_o;
        r_rsp_ninf <= core_ninf_o;
        r_rsp_err  <= 1'b0;
      end else if (r_cnt == c_tmo) begin
        r_rsp_sign <= 1'b1;
        r_rsp_exp  <= 7'sd16;
        r_rsp_mant <= 11'b100_0000_0000;
        r_rsp_nan  <= 1'b1;
        r_rsp_pinf <= 1'b0;
        r_rsp_ninf <= 1'b0;
        r_rsp_err  <= 1'b1;
      end
    end
  end

  // One-hot response strobe decoded from registered state and grant
  always_comb begin
    w_rsp_v = '0;
    if (r_state == S_RESP) w_rsp_v[r_grant] = 1'b1;
  end

  // Enable is low in IDLE and RESP so the sticky core done state clears
  assign core_enable  = (r_state == S_LAUNCH) || (r_state == S_WAIT);
  assign core_n_valid = (r_state == S_LAUNCH);
  assign core_sign    = r_op_sign;
  assign core_exp     = r_op_exp;
  assign core_mant    = r_op_mant;
  assign core_is_num  = r_op_flags[3];
  assign core_is_ninf = r_op_flags[2];
  assign core_is_pinf = r_op_flags[1];
  assign core_is_nan  = r_op_flags[0];

  assign req_ready = w_ready;
  assign rsp_valid = w_rsp_v;
  assign rsp_id    = (r_state == S_RESP) ? r_grant : '0;
  assign rsp_sign  = r_rsp_sign;
  assign rsp_exp   = r_rsp_exp;
  assign rsp_mant  = r_rsp_mant;
  assign rsp_nan   = r_rsp_nan;
  assign rsp_pinf  = r_rsp_pinf;
  assign rsp_ninf  = r_rsp_ninf;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire
